// File: rtl/sm_rr_sched.sv
// Round-robin scheduler that shares one sm_para-style FSM among N_REQ requesters.
// Each grant drives one burst of command beats, then completes through DRAIN or aborts on sm_err.
module sm_rr_sched #(
  parameter int   N_REQ       = 4,
  parameter int   BURST       = 4,
  parameter int   RECOVER_CYC = 2,
  parameter logic IDLE_I1     = 1'b1,
  parameter logic IDLE_I2     = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] cmd,
  output logic [N_REQ-1:0]   gnt,
  output logic               beat,
  output logic               sm_i1,
  output logic               sm_i2,
  input  logic               sm_o1,
  input  logic               sm_o2,
  input  logic               sm_err,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   abort,
  output logic [1:0]         status,
  output logic               busy
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int REC_W = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);
  localparam logic [REC_W-1:0] REC_LAST = REC_W'(RECOVER_CYC - 1);
  localparam logic [N_REQ-1:0] ONE      = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, RECOVER} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] g, g_next, ptr, ptr_next, pick, scan;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [REC_W-1:0] rc, rc_next;
  logic [N_REQ-1:0] gnt_next, done_next, abort_next, g_oh;
  logic             beat_next, i1_next, i2_next, found;
  logic [1:0]       status_next;

  assign g_oh = ONE << g;
  assign busy = (state != IDLE);

  // Search starts just after the last served requester so service rotates fairly.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    scan  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[scan]) begin
        found = 1'b1;
        pick  = scan;
      end
    end
  end

  always_comb begin
    state_next  = state;
    g_next      = g;
    ptr_next    = ptr;
    cnt_next    = cnt;
    rc_next     = rc;
    gnt_next    = gnt;
    beat_next   = 1'b0;
    i1_next     = IDLE_I1;
    i2_next     = IDLE_I2;
    done_next   = '0;
    abort_next  = '0;
    status_next = status;
    case (state)
      IDLE: begin
        if (found) begin
          g_next     = pick;
          gnt_next   = ONE << pick;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        if (sm_err) begin
          state_next = RECOVER;
        end else if (!req[g]) begin
          state_next = DRAIN;
        end else begin
          beat_next = 1'b1;
          i1_next   = cmd[{g, 1'b1}];
          i2_next   = cmd[{g, 1'b0}];
          if (cnt == CNT_LAST) state_next = DRAIN;
          else                 cnt_next   = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (sm_err) begin
          state_next = RECOVER;
        end else begin
          status_next = {sm_o1, sm_o2};
          done_next   = g_oh;
          gnt_next    = '0;
          ptr_next    = g;
          state_next  = IDLE;
        end
      end
      RECOVER: begin
        if (rc == REC_LAST) state_next = IDLE;
        else                rc_next    = rc + 1'b1;
      end
      default: state_next = IDLE;
    endcase
    // Common abort bookkeeping for errors seen in either RUN or DRAIN.
    if (state_next == RECOVER && state != RECOVER) begin
      abort_next = g_oh;
      gnt_next   = '0;
      ptr_next   = g;
      rc_next    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      g      <= '0;
      ptr    <= LAST_IDX;
      cnt    <= '0;
      rc     <= '0;
      gnt    <= '0;
      beat   <= 1'b0;
      sm_i1  <= IDLE_I1;
      sm_i2  <= IDLE_I2;
      done   <= '0;
      abort  <= '0;
      status <= 2'b00;
    end else begin
      state  <= state_next;
      g      <= g_next;
      ptr    <= ptr_next;
      cnt    <= cnt_next;
      rc     <= rc_next;
      gnt    <= gnt_next;
      beat   <= beat_next;
      sm_i1  <= i1_next;
      sm_i2  <= i2_next;
      done   <= done_next;
      abort  <= abort_next;
      status <= status_next;
    end
  end
endmodule
